db_fsm: RTL and testbench
=========================

Name: db_fsm

Overview:
- Debounce finite-state machine that consumes the periodic `tick` strobe from the debounce ticker and turns a raw mechanical switch/button input into a clean level.
- Also produces single-cycle rise and fall pulses.
- Sits between board pushbuttons and the TX_Out control logic, for example the "send" button that launches a UART transmit.
- The ticker decides *when* to sample; this block decides *whether* the input has been stable long enough.

Parameters:
- STABLE_TICKS, 3, number of consecutive ticks the synchronised input must hold a new value before the debounced output changes. Legal range 1..15. With a 10 ms tick, the default gives 20–30 ms.
- CNT_W, 4, width of the internal tick counter. Must satisfy 2^CNT_W > STABLE_TICKS.

Ports:
- clk  input  1  system clock (100 MHz on board)
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted
- sw  input  1  raw, asynchronous, bouncing switch input
- tick  input  1  one-cycle strobe from the debounce ticker, synchronous to clk
- db_level  output  1  debounced level of sw
- db_rise  output  1  one-cycle pulse when db_level goes 0->1
- db_fall  output  1  one-cycle pulse when db_level goes 1->0

Behaviour:
- Reset (reset=0, asynchronous):
  - synchroniser flops = 0, state = ZERO, counter = 0.
  - db_level = 0, db_rise = 0, db_fall = 0.
  - Deassertion is used as-is; it is not re-synchronised inside this block.
- Synchroniser:
  - 2-flop chain on sw produces sw_s.
  - All FSM decisions use sw_s only.
  - sw_s lags sw by 2 clk edges.
- States: ZERO, WAIT1, ONE, WAIT0 (2-bit encoding).
- ZERO:
  - sw_s=1 -> WAIT1, counter loads STABLE_TICKS.
  - Otherwise stay.
  - A tick in that same cycle is ignored.
- WAIT1:
  - sw_s=0 -> ZERO, counter cleared. This takes priority over a tick in the same cycle.
  - sw_s=1 & tick & counter==1 -> ONE.
  - sw_s=1 & tick & counter>1 -> counter-1.
  - No tick -> hold.
- ONE / WAIT0: exact mirror of ZERO / WAIT1 with the polarity inverted. WAIT0 with sw_s=0 confirmed -> ZERO.
- Outputs (all registered, no combinational path from sw or tick):
  - db_level = 1 exactly when state ∈ {ONE, WAIT0}.
  - db_rise = 1 for exactly the first clk cycle in which state==ONE after WAIT1.
  - db_fall = 1 for exactly the first cycle state==ZERO after WAIT0.
  - db_rise and db_fall are never both 1.
- Timing bound: a new level must be stable across STABLE_TICKS tick strobes after entry to the WAIT state. Stable time is therefore between (STABLE_TICKS-1) and STABLE_TICKS tick periods, plus 2 sync cycles plus 1 cycle.
- STABLE_TICKS=1: the first tick after entry confirms.
- A bounce back to the old level in a WAIT state aborts with no output change and no pulse.
- Reset mid-WAIT or in ONE: immediately ZERO, db_level=0, and no db_fall pulse is generated.
- sw held high through reset release: the block goes ZERO -> WAIT1 -> ONE with a normal db_rise pulse.
- Missing ticks (tick held 0): the FSM holds indefinitely in its WAIT state. No timeout.
- tick held 1 continuously (illegal but tolerated): counts on every cycle.

Decomposition:
- Shared package db_pkg: state encoding localparams ST_ZERO=2'b00, ST_WAIT1=2'b01, ST_ONE=2'b10, ST_WAIT0=2'b11, plus DEFAULT_STABLE_TICKS=3.
- One sub-module: sync_2ff (2-flop synchroniser, async active-low reset to 0), reused later for other board inputs.
- The ticker stays a separate instance at top level; this block only receives its tick.

Test Plan:
- Bench uses tick every 10 clk cycles.
- Reset: hold reset=0 for 5 cycles with sw=1 -> db_level=0, db_rise=0, db_fall=0 throughout. After release, db_rise pulses exactly once and db_level=1 within 2+30+1 cycles.
- Clean press: sw 0->1 and held 100 cycles -> db_level rises 22–33 cycles after the sw edge; db_rise is high exactly 1 cycle, in the same cycle db_level first =1.
- Bounce: sw toggles every 3 cycles for 40 cycles, then settles at 1 -> no db_rise during the toggling; a single db_rise 22–33 cycles after the last edge.
- Glitch abort: from ONE, sw=0 for 15 cycles (fewer than 3 ticks), then back to 1 -> db_level stays 1, db_fall never asserts.
- Simultaneous events: in WAIT1 with counter==1, drive sw_s=0 in the same cycle as the tick -> next state ZERO, db_level=0, no pulse.
- Reset mid-operation: assert reset while in WAIT0 -> db_level=0 asynchronously, state ZERO, db_fall stays 0; with STABLE_TICKS=1 the rebuild confirms on the first tick.

Source files
------------

// File: rtl/db_pkg.sv
// db_pkg: shared state encoding and defaults for the debounce FSM.
package db_pkg;
    localparam logic [1:0] ST_ZERO  = 2'b00;
    localparam logic [1:0] ST_WAIT1 = 2'b01;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_WAIT0 = 2'b11;
    localparam int DEFAULT_STABLE_TICKS = 3;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous board input.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk or negedge reset)
        if (!reset) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/db_fsm.sv
// db_fsm: debounces a raw switch into a clean level plus rise/fall pulses.
// The level only changes after the new value survives STABLE_TICKS tick strobes.
module db_fsm
    import db_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    input  logic tick,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(STABLE_TICKS);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    logic sw_s;
    logic [1:0] state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    sync_2ff u_sync (.clk(clk), .reset(reset), .d(sw), .q(sw_s));
    // A bounce back to the old level wins over a tick in the same cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_ZERO: if (sw_s) begin
                state_nx = ST_WAIT1;
                cnt_nx   = LOAD;
            end
            ST_WAIT1: if (!sw_s) begin
                state_nx = ST_ZERO;
                cnt_nx   = '0;
            end else if (tick) begin
                state_nx = (cnt == ONE) ? ST_ONE : ST_WAIT1;
                cnt_nx   = (cnt == ONE) ? '0 : cnt - ONE;
            end
            ST_ONE: if (!sw_s) begin
                state_nx = ST_WAIT0;
                cnt_nx   = LOAD;
            end
            default: if (sw_s) begin
                state_nx = ST_ONE;
                cnt_nx   = '0;
            end else if (tick) begin
                state_nx = (cnt == ONE) ? ST_ZERO : ST_WAIT0;
                cnt_nx   = (cnt == ONE) ? '0 : cnt - ONE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= ST_ZERO;
            cnt      <= '0;
            db_level <= 1'b0;
            db_rise  <= 1'b0;
            db_fall  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            db_level <= state_nx[1];
            db_rise  <= (state == ST_WAIT1) && (state_nx == ST_ONE);
            db_fall  <= (state == ST_WAIT0) && (state_nx == ST_ZERO);
        end
endmodule

// File: tb/tb_db_fsm.sv
// tb_db_fsm: random and directed stimulus against a tick-counting debounce model.
module tb_db_fsm;
    logic clk = 0, reset = 0, sw = 0, tick = 0;
    logic [1:0] lev, ri, fa;
    int n_checks = 0, n_errors = 0, cyc = 0, t_edge = 0, t_rise = 0, rise_cnt = 0, fall_cnt = 0;
    int nt[2] = '{3, 1};
    logic ms1[2], ms2[2], mlvl[2], mpend[2], mrise[2], mfall[2];
    int mcnt[2];

    always #5 clk = ~clk;

    db_fsm #(.STABLE_TICKS(3)) u_db3 (.clk(clk), .reset(reset), .sw(sw), .tick(tick),
        .db_level(lev[0]), .db_rise(ri[0]), .db_fall(fa[0]));
    db_fsm #(.STABLE_TICKS(1)) u_db1 (.clk(clk), .reset(reset), .sw(sw), .tick(tick),
        .db_level(lev[1]), .db_rise(ri[1]), .db_fall(fa[1]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms1[k] = 0; ms2[k] = 0; mlvl[k] = 0; mpend[k] = 0;
            mrise[k] = 0; mfall[k] = 0; mcnt[k] = 0;
        end
    endtask

    // A differing synchronised level must be seen, then survive nt ticks.
    task automatic model_edge();
        logic s;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            s = ms2[k];
            ms2[k] = ms1[k];
            ms1[k] = sw;
            mrise[k] = 0;
            mfall[k] = 0;
            if (s == mlvl[k]) mpend[k] = 0;
            else if (!mpend[k]) begin
                mpend[k] = 1;
                mcnt[k] = 0;
            end else if (tick) begin
                mcnt[k]++;
                if (mcnt[k] == nt[k]) begin
                    mlvl[k] = s;
                    mpend[k] = 0;
                    mrise[k] = s;
                    mfall[k] = !s;
                end
            end
        end
    endtask

    task automatic step_t(input logic v, input logic t);
        cyc++;
        if (v !== sw) t_edge = cyc;
        sw = v;
        tick = t;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        if (ri[0]) begin
            rise_cnt++;
            t_rise = cyc;
        end
        if (fa[0]) fall_cnt++;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("level_n%0d", nt[k]), 32'(lev[k]), 32'(mlvl[k]));
            check($sformatf("rise_n%0d", nt[k]), 32'(ri[k]), 32'(mrise[k]));
            check($sformatf("fall_n%0d", nt[k]), 32'(fa[k]), 32'(mfall[k]));
        end
    endtask

    task automatic step(input logic v);
        step_t(v, (cyc % 10) == 9);
    endtask

    task automatic run(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin
        logic v;
        int len, mode;
        model_reset();
        // reset held with sw high, then release: one rise
        for (int i = 0; i < 5; i++) step(1);
        reset = 1;
        rise_cnt = 0;
        run(1, 40);
        check("reset_release_rises", rise_cnt, 1);
        check("reset_release_level", 32'(lev[0]), 1);
        // clean press
        run(0, 60);
        rise_cnt = 0;
        run(1, 100);
        check("press_rises", rise_cnt, 1);
        check("press_latency", 32'((t_rise - t_edge) >= 22 && (t_rise - t_edge) <= 33), 1);
        // bounce then settle high
        run(0, 60);
        rise_cnt = 0;
        for (int i = 0; i < 14; i++) run(!i[0], 3);
        check("bounce_no_rise", rise_cnt, 0);
        run(1, 60);
        check("bounce_rises", rise_cnt, 1);
        check("bounce_latency", 32'((t_rise - t_edge) >= 22 && (t_rise - t_edge) <= 33), 1);
        // glitch low shorter than three ticks
        fall_cnt = 0;
        run(0, 15);
        run(1, 60);
        check("glitch_no_fall", fall_cnt, 0);
        check("glitch_level", 32'(lev[0]), 1);
        // bounce back on the confirming tick: abort wins
        run(0, 60);
        rise_cnt = 0;
        for (int i = 0; i < 3; i++) step_t(1, 0);
        step_t(1, 1);
        step_t(1, 1);
        step_t(0, 0);
        step_t(0, 0);
        step_t(0, 1);
        check("simul_level", 32'(lev[0]), 0);
        check("simul_rises", rise_cnt, 0);
        // asynchronous reset while in WAIT0
        run(1, 60);
        for (int i = 0; i < 6; i++) step_t(0, 0);
        fall_cnt = 0;
        #2 reset = 0;
        #1;
        check("async_level_n3", 32'(lev[0]), 0);
        check("async_level_n1", 32'(lev[1]), 0);
        check("async_fall_n3", 32'(fa[0]), 0);
        for (int i = 0; i < 3; i++) step(1);
        reset = 1;
        run(1, 40);
        check("rebuild_no_fall", fall_cnt, 0);
        check("rebuild_level_n1", 32'(lev[1]), 1);
        // random segments; some with tick stuck high or low
        for (int i = 0; i < 60; i++) begin
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            mode = $urandom_range(0, 7);
            for (int j = 0; j < len; j++)
                step_t(v, mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : 1'((cyc % 10) == 9));
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
